// File: rtl/full_adder_mux2_1.sv
// Registered WIDTH-bit two's-complement add/subtract unit: a mux selects B or ~B,
// a ripple chain of full_adder cells forms the result, and result plus flags are registered.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module mux2_1 #(
    parameter int WIDTH = 64
) (
    input  logic [1:0][WIDTH-1:0] mux_in,
    input  logic                  sel,
    output logic [WIDTH-1:0]      mux_out
);
    assign mux_out = mux_in[sel];
endmodule

module full_adder_mux2_1 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic [WIDTH-1:0] S,
    output logic             carry_out,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);
    logic [1:0][WIDTH-1:0] mux_in;
    logic [WIDTH-1:0]      b_op;
    logic [WIDTH-1:0]      sum;
    logic [WIDTH:0]        c;

    logic [WIDTH-1:0] s_d, s_q;
    logic             carry_d, carry_q;
    logic             ovf_d, ovf_q;
    logic             neg_d, neg_q;
    logic             zero_d, zero_q;

    assign mux_in[0] = B;
    assign mux_in[1] = ~B;

    mux2_1 #(.WIDTH(WIDTH)) u_bsel (
        .mux_in  (mux_in),
        .sel     (Sub),
        .mux_out (b_op)
    );

    // Sub doubles as the carry-in so that A + ~B + 1 yields A - B.
    assign c[0] = Sub;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
            full_adder u_fa (
                .a    (A[gi]),
                .b    (b_op[gi]),
                .cin  (c[gi]),
                .s    (sum[gi]),
                .cout (c[gi+1])
            );
        end
    endgenerate

    always_comb begin
        s_d     = sum;
        carry_d = c[WIDTH];
        ovf_d   = c[WIDTH] ^ c[WIDTH-1];
        neg_d   = sum[WIDTH-1];
        zero_d  = (sum == '0);
    end

    // Reset clears every output, including zero, even though S is then 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            s_q     <= s_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
        end
    end

    assign S         = s_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign negative  = neg_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_full_adder_mux2_1.sv
// Bench for full_adder_mux2_1: directed vector table, reset sequences and
// randomized operations checked against an arithmetic reference model.

module tb_full_adder_mux2_1;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] A, B;
    logic         Sub;
    logic [W-1:0] S;
    logic         carry_out, overflow, negative, zero;

    int n_vec = 0;
    int n_bad = 0;

    full_adder_mux2_1 #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .A         (A),
        .B         (B),
        .Sub       (Sub),
        .S         (S),
        .carry_out (carry_out),
        .overflow  (overflow),
        .negative  (negative),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         n;
        logic         z;
    } vec_t;

    // Reference: unsigned result and carry from plain arithmetic, overflow
    // from exact signed arithmetic compared with the wrapped result.
    function automatic logic [W+3:0] ref_model(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic sub);
        logic [W-1:0]        r;
        logic                cy;
        logic signed [W+1:0] exact;
        logic signed [W+1:0] wrapped;
        logic                v;
        if (sub) begin
            r     = a - b;
            cy    = (a >= b);
            exact = $signed({a[W-1], a[W-1], a}) - $signed({b[W-1], b[W-1], b});
        end else begin
            {cy, r} = {1'b0, a} + {1'b0, b};
            exact   = $signed({a[W-1], a[W-1], a}) + $signed({b[W-1], b[W-1], b});
        end
        wrapped = $signed({r[W-1], r[W-1], r});
        v = (exact != wrapped);
        return {r, cy, v, r[W-1], (r == '0)};
    endfunction

    task automatic check(input string name, input logic [W-1:0] es,
                         input logic ec, input logic ev, input logic en, input logic ez);
        n_vec++;
        if ({S, carry_out, overflow, negative, zero} !== {es, ec, ev, en, ez}) begin
            n_bad++;
            $display("FAIL %s: got S=%h c=%b v=%b n=%b z=%b, required S=%h c=%b v=%b n=%b z=%b",
                     name, S, carry_out, overflow, negative, zero, es, ec, ev, en, ez);
        end else begin
            $display("ok   %s: S=%h c=%b v=%b n=%b z=%b",
                     name, S, carry_out, overflow, negative, zero);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[7];

    initial begin
        logic [W+3:0] e;

        tbl[0] = '{64'd4321, 64'd5678, 1'b0, 64'd9999, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{64'd5678, 64'd1234, 1'b1, 64'd4444, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{64'd5, 64'd5, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset held two edges with non-zero operands.
        reset = 1'b1; A = 64'd123; B = 64'd456; Sub = 1'b0;
        step();
        check("reset_edge1", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("reset_edge2", '0, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            A = tbl[i].a; B = tbl[i].b; Sub = tbl[i].sub;
            step();
            check($sformatf("table%0d", i), tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].n, tbl[i].z);
            @(negedge clk);
        end

        // Back-to-back then reset mid-stream: reset must win over a live operation.
        A = 64'd5; B = 64'd5; Sub = 1'b1;
        step();
        check("b2b_sub_self", '0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1; A = 64'd7; B = 64'd3; Sub = 1'b0;
        step();
        check("midstream_reset", '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("after_reset_add", 64'd10, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized stream, one new operation per cycle.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            A   = {$urandom, $urandom};
            B   = (i % 8 == 0) ? A : {$urandom, $urandom};
            Sub = $urandom_range(0, 1);
            if (i % 16 == 3) A[W-1] = ~B[W-1];
            e = ref_model(A, B, Sub);
            step();
            check($sformatf("rand%0d", i), e[W+3:4], e[3], e[2], e[1], e[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
